dcache_access_ctrl: RTL and testbench

MEM-stage controller between the EXE/MEM pipeline register and the data cache. It issues one Dcache request per load or store, holds the request until the cache acknowledges, and stalls the pipeline meanwhile. For stores it generates byte enables and lane-replicated write data. For loads it registers the returned word and right-shifts it so the addressed byte or half sits at bit 0, which is the form `load_extension` consumes.

---
 rtl/mem_pkg.sv | 16 +
 rtl/mem_lane_align.sv | 42 ++++
 rtl/dcache_access_ctrl.sv | 124 ++++++++++++
 tb/tb_dcache_access_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared MEM-stage definitions: Dcache controller states, memory opcodes
// and funct3 access-size encodings.
package mem_pkg;

  typedef enum logic [1:0] {IDLE, REQ, DONE} dc_state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane logic: store byte enables and replicated write
// data, load-word right-alignment, and the natural-alignment check.
module mem_lane_align
  import mem_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [2:0]    i_funct3,
  input  logic [1:0]    i_off,
  input  logic [DW-1:0] i_rs2,
  input  logic [DW-1:0] i_rdata,
  output logic [3:0]    o_be,
  output logic [DW-1:0] o_wdata,
  output logic [DW-1:0] o_rdata_sh,
  output logic          o_misalign
);

  always_comb begin
    o_be       = 4'b0000;
    o_wdata    = '0;
    o_misalign = 1'b0;
    case (i_funct3)
      F3_B, F3_BU: begin
        o_be    = 4'b0001 << i_off;
        o_wdata = {(DW/8){i_rs2[7:0]}};
      end
      F3_H, F3_HU: begin
        o_be       = 4'b0011 << i_off;
        o_wdata    = {(DW/16){i_rs2[15:0]}};
        o_misalign = i_off[0];
      end
      default: begin
        // Word and any unused encoding are treated as full-word accesses.
        o_be       = 4'b1111;
        o_wdata    = i_rs2;
        o_misalign = |i_off;
      end
    endcase
    o_rdata_sh = i_rdata >> {i_off, 3'b000};
  end

endmodule

// File: rtl/dcache_access_ctrl.sv
// MEM-stage Dcache controller: one request per aligned load/store, held until
// DC_ready, stalling the pipeline meanwhile; loads return a right-aligned word.
`ifndef DATA_SIZE
`define DATA_SIZE 32
`endif

module dcache_access_ctrl
  import mem_pkg::*;
#(
  parameter int DW = `DATA_SIZE
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          valid_EXE_MEM,
  input  logic [6:0]    opcode_EXE_MEM,
  input  logic [2:0]    funct3_EXE_MEM,
  input  logic [DW-1:0] alu_out_EXE_MEM,
  input  logic [DW-1:0] rs2_data_EXE_MEM,
  output logic          DC_req,
  output logic          DC_write,
  output logic [DW-1:0] DC_addr,
  output logic [3:0]    DC_be,
  output logic [DW-1:0] DC_wdata,
  input  logic [DW-1:0] DC_rdata,
  input  logic          DC_ready,
  output logic [DW-1:0] Dcache_out,
  output logic          stall_MEM,
  output logic          misalign_exc
);

  dc_state_t     r_state, w_state_nx;
  logic [DW-1:0] r_addr, r_wdata, r_dout;
  logic [3:0]    r_be;
  logic [1:0]    r_off;
  logic          r_write;

  logic          w_is_store, w_is_mem, w_issue, w_capture, w_misalign;
  logic [1:0]    w_off;
  logic [3:0]    w_be;
  logic [DW-1:0] w_wdata, w_rdata_sh;

  assign w_is_store = (opcode_EXE_MEM == OP_STORE);
  assign w_is_mem   = valid_EXE_MEM && ((opcode_EXE_MEM == OP_LOAD) || w_is_store);

  // Outside IDLE the lane logic must see the latched offset so the returned
  // word is shifted for the request in flight, not for whatever sits in EXE/MEM.
  assign w_off = (r_state == IDLE) ? alu_out_EXE_MEM[1:0] : r_off;

  mem_lane_align #(.DW(DW)) u_lane_align (
    .i_funct3   (funct3_EXE_MEM),
    .i_off      (w_off),
    .i_rs2      (rs2_data_EXE_MEM),
    .i_rdata    (DC_rdata),
    .o_be       (w_be),
    .o_wdata    (w_wdata),
    .o_rdata_sh (w_rdata_sh),
    .o_misalign (w_misalign)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nx;
  end

  // rst_n gates the IDLE decode so stall and misalign stay low while held in reset.
  always_comb begin
    w_state_nx   = r_state;
    w_issue      = 1'b0;
    w_capture    = 1'b0;
    DC_req       = 1'b0;
    stall_MEM    = 1'b0;
    misalign_exc = 1'b0;
    case (r_state)
      IDLE: begin
        if (rst_n && w_is_mem) begin
          if (w_misalign) begin
            misalign_exc = 1'b1;
          end else begin
            stall_MEM  = 1'b1;
            w_issue    = 1'b1;
            w_state_nx = REQ;
          end
        end
      end
      REQ: begin
        DC_req    = 1'b1;
        stall_MEM = 1'b1;
        if (DC_ready) begin
          w_capture  = !r_write;
          w_state_nx = DONE;
        end
      end
      DONE:    w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr  <= '0;
      r_off   <= 2'b00;
      r_write <= 1'b0;
      r_be    <= 4'b0000;
      r_wdata <= '0;
      r_dout  <= '0;
    end else begin
      if (w_issue) begin
        r_addr  <= {alu_out_EXE_MEM[DW-1:2], 2'b00};
        r_off   <= alu_out_EXE_MEM[1:0];
        r_write <= w_is_store;
        r_be    <= w_be;
        r_wdata <= w_wdata;
      end
      if (w_capture) r_dout <= w_rdata_sh;
    end
  end

  assign DC_addr    = r_addr;
  assign DC_write   = (r_state != IDLE) && r_write;
  assign DC_be      = (r_state == IDLE) ? 4'b0000 : r_be;
  assign DC_wdata   = (r_state == IDLE) ? '0 : r_wdata;
  assign Dcache_out = r_dout;

endmodule

// File: tb/tb_dcache_access_ctrl.sv
// Bench for dcache_access_ctrl: directed scenarios plus randomized ops
// checked against an arithmetic model of the access rules.
module tb_dcache_access_ctrl;

  localparam logic [6:0] OPL = 7'b0000011;
  localparam logic [6:0] OPS = 7'b0100011;
  localparam logic [6:0] OPR = 7'b0110011;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic [6:0]  opcode = '0;
  logic [2:0]  f3 = '0;
  logic [31:0] alu = '0, rs2 = '0, rdata = '0;
  logic        ready = 1'b0;

  logic        DC_req, DC_write, stall_MEM, misalign_exc;
  logic [31:0] DC_addr, DC_wdata, Dcache_out;
  logic [3:0]  DC_be;

  dcache_access_ctrl #(.DW(32)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .valid_EXE_MEM    (valid),
    .opcode_EXE_MEM   (opcode),
    .funct3_EXE_MEM   (f3),
    .alu_out_EXE_MEM  (alu),
    .rs2_data_EXE_MEM (rs2),
    .DC_req           (DC_req),
    .DC_write         (DC_write),
    .DC_addr          (DC_addr),
    .DC_be            (DC_be),
    .DC_wdata         (DC_wdata),
    .DC_rdata         (rdata),
    .DC_ready         (ready),
    .Dcache_out       (Dcache_out),
    .stall_MEM        (stall_MEM),
    .misalign_exc     (misalign_exc)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] m_dout = '0;

  // Observations collected by do_op
  int          o_stalls, o_nreq, o_mis_cnt;
  bit          o_stable, o_timeout;
  logic [31:0] o_addr, o_wd, o_dout, o_idle_wd;
  logic [3:0]  o_be, o_idle_be;
  logic        o_wr;

  function automatic int nbytes(input logic [2:0] fn);
    case (fn)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction

  // Present one instruction in EXE/MEM (called at a negedge) and act as the
  // cache: DC_ready rises in the (waitc+1)-th request cycle. Returns at a negedge.
  task automatic do_op(input logic [6:0] op, input logic [2:0] fn, input logic [31:0] a,
                       input logic [31:0] d2, input logic [31:0] rd, input int waitc);
    bit fin;
    fin = 0;
    o_stalls = 0; o_nreq = 0; o_mis_cnt = 0; o_stable = 1; o_timeout = 0;
    o_addr = 'x; o_be = 'x; o_wd = 'x; o_wr = 'x;
    valid = 1'b1; opcode = op; f3 = fn; alu = a; rs2 = d2; ready = 1'b0;
    for (int c = 0; c < 64 && !fin; c++) begin
      #1;
      if (misalign_exc) o_mis_cnt++;
      if (stall_MEM) o_stalls++;
      if (c == 0) begin o_idle_be = DC_be; o_idle_wd = DC_wdata; end
      if (DC_req) begin
        o_nreq++;
        if (o_nreq == 1) begin
          o_addr = DC_addr; o_be = DC_be; o_wd = DC_wdata; o_wr = DC_write;
        end else if ({DC_addr, DC_be, DC_wdata, DC_write} !== {o_addr, o_be, o_wd, o_wr}) begin
          o_stable = 0;
        end
        ready = (o_nreq == waitc + 1);
        rdata = ready ? rd : $urandom;
      end else begin
        ready = 1'($urandom_range(0, 1));
        rdata = $urandom;
        if (c == 0 && !stall_MEM) fin = 1;
        else if (o_nreq > 0) fin = 1;
      end
      if (fin) o_dout = Dcache_out;
      @(negedge clk);
    end
    valid = 1'b0; opcode = '0; ready = 1'b0;
    if (!fin) o_timeout = 1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    n_tests++; if (DC_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b want 0", DC_req); end
    n_tests++; if (DC_write !== 1'b0) begin n_fail++; $display("FAIL reset_write got %b want 0", DC_write); end
    n_tests++; if (DC_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr got %h want 0", DC_addr); end
    n_tests++; if ({DC_be, DC_wdata} !== 36'h0) begin n_fail++; $display("FAIL reset_be_wdata got %h/%h want 0", DC_be, DC_wdata); end
    n_tests++; if (Dcache_out !== 32'h0) begin n_fail++; $display("FAIL reset_dout got %h want 0", Dcache_out); end
    n_tests++; if ({stall_MEM, misalign_exc} !== 2'b00) begin n_fail++; $display("FAIL reset_stall_mis got %b want 00", {stall_MEM, misalign_exc}); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_lw_basic();
    do_op(OPL, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0);
    n_tests++; if (o_timeout) begin n_fail++; $display("FAIL lw_timeout got timeout want done"); end
    n_tests++; if (o_addr !== 32'h100) begin n_fail++; $display("FAIL lw_addr got %h want 00000100", o_addr); end
    n_tests++; if (o_be !== 4'b1111) begin n_fail++; $display("FAIL lw_be got %b want 1111", o_be); end
    n_tests++; if (o_wr !== 1'b0) begin n_fail++; $display("FAIL lw_write got %b want 0", o_wr); end
    n_tests++; if (o_stalls != 2) begin n_fail++; $display("FAIL lw_stalls got %0d want 2", o_stalls); end
    n_tests++; if (o_dout !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lw_dout got %h want deadbeef", o_dout); end
    n_tests++; if (o_idle_be !== 4'b0000) begin n_fail++; $display("FAIL lw_idle_be got %b want 0000", o_idle_be); end
  endtask

  task automatic test_lb_offset();
    do_op(OPL, 3'b000, 32'h103, 32'h0, 32'h80FFFFFF, 0);
    n_tests++; if (o_dout !== 32'h00000080) begin n_fail++; $display("FAIL lb_dout got %h want 00000080", o_dout); end
    n_tests++; if (o_be !== 4'b1000) begin n_fail++; $display("FAIL lb_be got %b want 1000", o_be); end
    n_tests++; if (o_addr !== 32'h100) begin n_fail++; $display("FAIL lb_addr got %h want 00000100", o_addr); end
  endtask

  task automatic test_sh_store();
    do_op(OPS, 3'b001, 32'h202, 32'h1234ABCD, 32'hFFFF0000, 0);
    n_tests++; if (o_addr !== 32'h200) begin n_fail++; $display("FAIL sh_addr got %h want 00000200", o_addr); end
    n_tests++; if (o_be !== 4'b1100) begin n_fail++; $display("FAIL sh_be got %b want 1100", o_be); end
    n_tests++; if (o_wd !== 32'hABCDABCD) begin n_fail++; $display("FAIL sh_wdata got %h want abcdabcd", o_wd); end
    n_tests++; if (o_wr !== 1'b1) begin n_fail++; $display("FAIL sh_write got %b want 1", o_wr); end
    n_tests++; if (o_dout !== 32'h00000080) begin n_fail++; $display("FAIL sh_dout_held got %h want 00000080", o_dout); end
  endtask

  task automatic test_wait_states();
    do_op(OPL, 3'b010, 32'h300, 32'h0, 32'h55AA55AA, 3);
    n_tests++; if (o_stalls != 5) begin n_fail++; $display("FAIL wait_stalls got %0d want 5", o_stalls); end
    n_tests++; if (o_nreq != 4) begin n_fail++; $display("FAIL wait_req_cycles got %0d want 4", o_nreq); end
    n_tests++; if (!o_stable) begin n_fail++; $display("FAIL wait_stable got unstable want stable"); end
    n_tests++; if (o_addr !== 32'h300) begin n_fail++; $display("FAIL wait_addr got %h want 00000300", o_addr); end
    n_tests++; if (o_dout !== 32'h55AA55AA) begin n_fail++; $display("FAIL wait_dout got %h want 55aa55aa", o_dout); end
  endtask

  task automatic test_misalign();
    do_op(OPL, 3'b010, 32'h102, 32'h0, 32'h12345678, 0);
    n_tests++; if (o_mis_cnt != 1) begin n_fail++; $display("FAIL mis_flag got %0d cycles want 1", o_mis_cnt); end
    n_tests++; if (o_nreq != 0) begin n_fail++; $display("FAIL mis_req got %0d want 0", o_nreq); end
    n_tests++; if (o_stalls != 0) begin n_fail++; $display("FAIL mis_stall got %0d want 0", o_stalls); end
    #1;
    n_tests++; if ({DC_req, stall_MEM, misalign_exc} !== 3'b000) begin n_fail++; $display("FAIL mis_after got %b want 000", {DC_req, stall_MEM, misalign_exc}); end
    n_tests++; if (Dcache_out !== 32'h55AA55AA) begin n_fail++; $display("FAIL mis_dout_held got %h want 55aa55aa", Dcache_out); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    do_op(OPS, 3'b010, 32'h500, 32'hCAFEF00D, 32'h0, 0);
    n_tests++; if ({o_be, o_wd} !== {4'b1111, 32'hCAFEF00D}) begin n_fail++; $display("FAIL b2b_sw got %b/%h want 1111/cafef00d", o_be, o_wd); end
    n_tests++; if (o_stalls != 2) begin n_fail++; $display("FAIL b2b_sw_stalls got %0d want 2", o_stalls); end
    do_op(OPL, 3'b101, 32'h506, 32'h0, 32'hBEEF1234, 1);
    n_tests++; if (o_stalls != 3) begin n_fail++; $display("FAIL b2b_lhu_stalls got %0d want 3", o_stalls); end
    n_tests++; if (o_dout !== 32'h0000BEEF) begin n_fail++; $display("FAIL b2b_lhu_dout got %h want 0000beef", o_dout); end
    n_tests++; if (o_be !== 4'b1100) begin n_fail++; $display("FAIL b2b_lhu_be got %b want 1100", o_be); end
  endtask

  task automatic test_reset_mid_req();
    valid = 1'b1; opcode = OPL; f3 = 3'b010; alu = 32'h400; ready = 1'b0;
    @(negedge clk);
    #1;
    n_tests++; if ({DC_req, stall_MEM} !== 2'b11) begin n_fail++; $display("FAIL rstreq_in_req got %b want 11", {DC_req, stall_MEM}); end
    rst_n = 1'b0;
    #1;
    n_tests++; if ({DC_req, stall_MEM} !== 2'b00) begin n_fail++; $display("FAIL rstreq_async got %b want 00", {DC_req, stall_MEM}); end
    valid = 1'b0; opcode = '0;
    @(negedge clk);
    rst_n = 1'b1;
    do_op(OPL, 3'b010, 32'h404, 32'h0, 32'h11223344, 1);
    n_tests++; if (o_timeout || o_dout !== 32'h11223344) begin n_fail++; $display("FAIL rstreq_next_lw got %h want 11223344", o_dout); end
    n_tests++; if (o_stalls != 3) begin n_fail++; $display("FAIL rstreq_next_stalls got %0d want 3", o_stalls); end
    m_dout = 32'h11223344;
  endtask

  task automatic test_random();
    logic [2:0] lf [5];
    lf = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    for (int i = 0; i < 60; i++) begin
      logic [6:0]  op;
      logic [2:0]  fn;
      logic [31:0] a, d2, rd, e_wd;
      logic [3:0]  e_be;
      int          k, waitc, n, off;
      bit          mem, mis, issue;
      k = $urandom_range(0, 9);
      if (k < 5)      begin op = OPL; fn = lf[$urandom_range(0, 4)]; end
      else if (k < 8) begin op = OPS; fn = 3'($urandom_range(0, 2)); end
      else            begin op = OPR; fn = 3'($urandom_range(0, 7)); end
      a = $urandom; d2 = $urandom; rd = $urandom; waitc = $urandom_range(0, 3);
      n = nbytes(fn); off = int'(a[1:0]);
      mem = (op == OPL) || (op == OPS);
      mis = mem && ((off % n) != 0);
      issue = mem && !mis;
      e_be = 4'(((1 << n) - 1) << off);
      e_wd = '0;
      for (int j = 0; j < 4 / n; j++) e_wd |= 32'((64'(d2) & ((64'd1 << (8 * n)) - 1)) << (8 * n * j));
      if (issue && op == OPL) m_dout = rd >> (8 * off);
      do_op(op, fn, a, d2, rd, waitc);
      n_tests++; if (o_timeout) begin n_fail++; $display("FAIL rnd%0d_timeout got timeout want done", i); end
      n_tests++; if (o_stalls != (issue ? 2 + waitc : 0)) begin n_fail++; $display("FAIL rnd%0d_stalls got %0d want %0d", i, o_stalls, issue ? 2 + waitc : 0); end
      n_tests++; if (o_nreq != (issue ? waitc + 1 : 0)) begin n_fail++; $display("FAIL rnd%0d_req got %0d want %0d", i, o_nreq, issue ? waitc + 1 : 0); end
      n_tests++; if (o_mis_cnt != (mis ? 1 : 0)) begin n_fail++; $display("FAIL rnd%0d_mis got %0d want %0d", i, o_mis_cnt, mis ? 1 : 0); end
      n_tests++; if (o_dout !== m_dout) begin n_fail++; $display("FAIL rnd%0d_dout got %h want %h", i, o_dout, m_dout); end
      n_tests++; if ({o_idle_be, o_idle_wd} !== 36'h0) begin n_fail++; $display("FAIL rnd%0d_idle_lanes got %b/%h want 0", i, o_idle_be, o_idle_wd); end
      if (issue) begin
        n_tests++; if (o_addr !== {a[31:2], 2'b00}) begin n_fail++; $display("FAIL rnd%0d_addr got %h want %h", i, o_addr, {a[31:2], 2'b00}); end
        n_tests++; if (o_be !== e_be) begin n_fail++; $display("FAIL rnd%0d_be got %b want %b", i, o_be, e_be); end
        n_tests++; if (o_wr !== (op == OPS)) begin n_fail++; $display("FAIL rnd%0d_write got %b want %b", i, o_wr, op == OPS); end
        n_tests++; if (!o_stable) begin n_fail++; $display("FAIL rnd%0d_stable got unstable want stable", i); end
        if (op == OPS) begin
          n_tests++; if (o_wd !== e_wd) begin n_fail++; $display("FAIL rnd%0d_wdata got %h want %h", i, o_wd, e_wd); end
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_lw_basic();
    test_lb_offset();
    test_sh_store();
    test_wait_states();
    test_misalign();
    test_back_to_back();
    test_reset_mid_req();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
